// File: rtl/param_mod_counter.sv
// Modulo up/down counter with enable prescaler, clamped parallel load and
// wrap/saturate boundary behaviour; tc pulses for one cycle after a limit step.
module param_mod_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULO   = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] x,
  output logic             tc,
  output logic             at_limit
);

  localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] X_MAX   = WIDTH'(MODULO - 1);
  localparam logic [PW-1:0]    P_MAX   = PW'(PRESCALE - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  logic [PW-1:0]    p;
  logic             step_c;
  logic [WIDTH-1:0] x_next_c;
  logic [WIDTH-1:0] load_clamp_c;

  always_comb begin
    at_limit = up_dn ? (x == X_MAX) : (x == '0);
  end

  assign step_c       = en && (p == P_MAX);
  assign load_clamp_c = ({1'b0, load_val} >= MOD_EXT) ? X_MAX : load_val;

  // Next count for a step; at the limit either wrap or hold.
  always_comb begin
    x_next_c = x;
    if (up_dn) begin
      if (x != X_MAX)     x_next_c = x + WIDTH'(1);
      else if (!sat_mode) x_next_c = '0;
    end else begin
      if (x != '0)        x_next_c = x - WIDTH'(1);
      else if (!sat_mode) x_next_c = X_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x  <= '0;
      p  <= '0;
      tc <= 1'b0;
    end else if (load) begin
      x  <= load_clamp_c;
      p  <= '0;
      tc <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (step_c) begin
        p  <= '0;
        x  <= x_next_c;
        tc <= at_limit;
      end else if (en) begin
        p <= p + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_param_mod_counter.sv
// Bench for param_mod_counter: vector table plus scoreboard queue, checking a
// MODULO=10/PRESCALE=3 instance and a MODULO=16/PRESCALE=1 instance.
module tb_param_mod_counter;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       sat;
    logic       load;
    logic [3:0] lv;
    logic [3:0] x;
    logic       tc;
    logic       al;
    logic       sel;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       sat_mode = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] x10, x16;
  logic       tc10, tc16, al10, al16;

  int total = 0;
  int bad = 0;
  int vec_no = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  param_mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .x(x10), .tc(tc10), .at_limit(al10)
  );

  param_mod_counter #(.WIDTH(4), .MODULO(16), .PRESCALE(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .x(x16), .tc(tc16), .at_limit(al16)
  );

  function automatic vec_t mk(input logic r, input logic e, input logic u,
                              input logic s, input logic l, input int lv,
                              input int ex, input logic etc, input logic eal,
                              input logic sel);
    vec_t v;
    v.rst_n = r; v.en = e; v.up_dn = u; v.sat = s; v.load = l;
    v.lv = 4'(lv); v.x = 4'(ex); v.tc = etc; v.al = eal; v.sel = sel;
    return v;
  endfunction

  task automatic check_one();
    vec_t e;
    logic [3:0] ax;
    logic atc, aal;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard vec=%0d: queue empty", vec_no);
      return;
    end
    e   = exp_q.pop_front();
    ax  = e.sel ? x16 : x10;
    atc = e.sel ? tc16 : tc10;
    aal = e.sel ? al16 : al10;
    if (ax !== e.x) begin
      bad++;
      $display("FAIL x vec=%0d dut%0d: got %0d want %0d", vec_no, e.sel ? 16 : 10, ax, e.x);
    end
    total++;
    if (atc !== e.tc) begin
      bad++;
      $display("FAIL tc vec=%0d dut%0d: got %b want %b", vec_no, e.sel ? 16 : 10, atc, e.tc);
    end
    total++;
    if (aal !== e.al) begin
      bad++;
      $display("FAIL at_limit vec=%0d dut%0d: got %b want %b", vec_no, e.sel ? 16 : 10, aal, e.al);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic drive(input vec_t v);
    rst_n = v.rst_n; en = v.en; up_dn = v.up_dn; sat_mode = v.sat;
    load = v.load; load_val = v.lv;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    vec_no++;
    check_one();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int xv;
    // Reset, then free-run up with wrap: step every 3rd enabled cycle.
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 31; k++) begin
      xv = (k / 3) % 10;
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, xv, (k == 30), (xv == 9), 0));
    end
    // Clamped load of 12, then count down with wrap 0 -> 9.
    tbl.push_back(mk(1, 1, 1, 0, 1, 12, 9, 0, 1, 0));
    for (int k = 1; k <= 30; k++) begin
      xv = (100 + 9 - k / 3) % 10;
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, xv, (k == 30), (xv == 0), 0));
    end
    // Saturate up from 8: holds at 9, tc on each step taken at 9.
    tbl.push_back(mk(1, 1, 1, 1, 1, 8, 8, 0, 0, 0));
    for (int k = 1; k <= 15; k++) begin
      xv = (k < 3) ? 8 : 9;
      tbl.push_back(mk(1, 1, 1, 1, 0, 0, xv, (k % 3 == 0) && (k >= 6), (xv == 9), 0));
    end
    // Saturate down at 0.
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, (k == 3), 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    // Enable pattern 1,0,0,1,1 from p=0: one step on the 3rd enabled cycle.
    tbl.push_back(mk(1, 0, 1, 0, 1, 2, 2, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 3, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

    // Reset mid-interval (p=2, x=5) beats load and discards the partial count.
    drive(mk(1, 0, 1, 0, 1, 5, 5, 0, 0, 0));
    drive(mk(1, 1, 1, 0, 0, 0, 5, 0, 0, 0));
    drive(mk(1, 1, 1, 0, 0, 0, 5, 0, 0, 0));
    drive(mk(0, 1, 1, 0, 1, 3, 0, 0, 0, 0));
    drive(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    // Load with en wins and clears the prescaler.
    drive(mk(1, 1, 1, 0, 1, 7, 7, 0, 0, 0));
    drive(mk(1, 1, 1, 0, 0, 0, 7, 0, 0, 0));
    drive(mk(1, 1, 1, 0, 0, 0, 7, 0, 0, 0));
    drive(mk(1, 1, 1, 0, 0, 0, 8, 0, 0, 0));

    // PRESCALE=1, MODULO=16 instance: counts every cycle, tc after 15->0.
    drive(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 17; k++)
      drive(mk(1, 1, 1, 0, 0, 0, k % 16, (k == 16), ((k % 16) == 15), 1));

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
